multi_channel_timer: RTL and testbench

MULTI_CHANNEL_TIMER -- requirements
Module: multi_channel_timer

---
 rtl/multi_channel_timer.sv | 139 +++++++++++++
 tb/tb_multi_channel_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_timer.sv
// Multi-channel down-counting timer with per-channel prescaler, one-shot/continuous
// modes, snapshot capture and per-channel timeout interrupts on a simple slave bus.
module multi_channel_timer #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PRE_W        = 8,
  parameter int unsigned RESET_PERIOD = 599,
  localparam int unsigned AW          = 3 + $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAP     = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_COUNT    = 3'd5;

  logic [CNT_W-1:0] count_q    [NUM_CH];
  logic [CNT_W-1:0] period_q   [NUM_CH];
  logic [CNT_W-1:0] snap_q     [NUM_CH];
  logic [PRE_W-1:0] prescale_q [NUM_CH];
  logic [PRE_W-1:0] pre_q      [NUM_CH];
  logic [NUM_CH-1:0] cont_q, ito_q, run_q, to_q, zero_q;

  logic [NUM_CH-1:0] cnt_zero, tick, evt, ch_wr;
  logic [31:0]       ch_sel;
  logic [2:0]        reg_sel;
  logic              wr_en;
  logic [31:0]       rd_mux;

  assign wr_en   = chipselect && !write_n;
  assign ch_sel  = 32'(address) >> 3;
  assign reg_sel = address[2:0];

  // Per-channel tick, timeout-edge and write-select decode
  always_comb begin
    cnt_zero = '0;
    tick     = '0;
    evt      = '0;
    ch_wr    = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      cnt_zero[n] = (count_q[n] == '0);
      tick[n]     = run_q[n] && (pre_q[n] == '0);
      evt[n]      = cnt_zero[n] && !zero_q[n];
      ch_wr[n]    = wr_en && (ch_sel == n);
    end
  end

  // Read mux; unselected or out-of-range channels read 0
  always_comb begin
    rd_mux = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (ch_sel == n) begin
        case (reg_sel)
          REG_STATUS:   rd_mux = {30'd0, run_q[n], to_q[n]};
          REG_CONTROL:  rd_mux = {30'd0, cont_q[n], ito_q[n]};
          REG_PERIOD:   rd_mux = 32'(period_q[n]);
          REG_SNAP:     rd_mux = 32'(snap_q[n]);
          REG_PRESCALE: rd_mux = 32'(prescale_q[n]);
          REG_COUNT:    rd_mux = 32'(count_q[n]);
          default:      rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= '0;
      cont_q   <= '0;
      ito_q    <= '0;
      run_q    <= '0;
      to_q     <= '0;
      zero_q   <= '0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        count_q[n]    <= CNT_W'(RESET_PERIOD);
        period_q[n]   <= CNT_W'(RESET_PERIOD);
        snap_q[n]     <= '0;
        prescale_q[n] <= '0;
        pre_q[n]      <= '0;
      end
    end else begin
      readdata <= rd_mux;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        zero_q[n] <= cnt_zero[n];

        // Timeout event beats a same-cycle clear
        if (evt[n])
          to_q[n] <= 1'b1;
        else if (ch_wr[n] && reg_sel == REG_STATUS)
          to_q[n] <= 1'b0;

        if (ch_wr[n] && reg_sel == REG_CONTROL) begin
          cont_q[n] <= writedata[1];
          ito_q[n]  <= writedata[0];
        end

        // START dominates STOP; one-shot ends on the reload tick
        if (ch_wr[n] && reg_sel == REG_CONTROL && writedata[2])
          run_q[n] <= 1'b1;
        else if (ch_wr[n] && reg_sel == REG_CONTROL && writedata[3])
          run_q[n] <= 1'b0;
        else if (tick[n] && cnt_zero[n] && !cont_q[n])
          run_q[n] <= 1'b0;

        if (ch_wr[n] && reg_sel == REG_PERIOD) begin
          period_q[n] <= writedata[CNT_W-1:0];
          count_q[n]  <= writedata[CNT_W-1:0];
          pre_q[n]    <= prescale_q[n];
        end else if (tick[n]) begin
          pre_q[n]   <= prescale_q[n];
          count_q[n] <= cnt_zero[n] ? period_q[n] : count_q[n] - CNT_W'(1);
        end else if (run_q[n]) begin
          pre_q[n] <= pre_q[n] - PRE_W'(1);
        end

        if (ch_wr[n] && reg_sel == REG_PRESCALE)
          prescale_q[n] <= writedata[PRE_W-1:0];

        if (ch_wr[n] && reg_sel == REG_SNAP)
          snap_q[n] <= count_q[n];
      end
    end
  end

  assign irq_vec = to_q & ito_q;
  assign irq     = |irq_vec;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer (3 channels): read expectations are queued
// when the address is driven and checked when readdata appears one cycle later.
module tb_multi_channel_timer;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned AW     = 5;
  localparam int R_STATUS = 0, R_CONTROL = 1, R_PERIOD = 2, R_SNAP = 3;
  localparam int R_PRESCALE = 4, R_COUNT = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  multi_channel_timer #(.NUM_CH(NUM_CH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each bus operation starts and ends on a falling edge and spans one rising edge
  task automatic wr(input int ch, input int rg, input logic [31:0] data);
    address    = AW'((ch << 3) | rg);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int ch, input int rg, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    address    = AW'((ch << 3) | rg);
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(readdata, e, t);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] seq0 [6];
    logic [31:0] seq1 [14];
    logic [31:0] st0  [4];
    seq0 = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd4};
    seq1 = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd1,
             32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd2};
    st0  = '{32'd2, 32'd2, 32'd2, 32'd3};

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    chk(readdata, 32'd0, "reset_readdata");
    chk(32'(irq), 32'd0, "reset_irq");
    chk(32'(irq_vec), 32'd0, "reset_irq_vec");
    reset_n = 1'b1;

    // Reset values, reserved registers, width masking, out-of-range channel
    rd(0, R_PERIOD, 32'd599, "ch0_period_reset");
    chk(32'(irq), 32'd0, "irq_after_reset");
    rd(0, R_COUNT, 32'd599, "ch0_count_reset");
    rd(1, R_PERIOD, 32'd599, "ch1_period_reset");
    rd(0, R_STATUS, 32'd0, "ch0_status_reset");
    rd(0, R_CONTROL, 32'd0, "ch0_control_reset");
    rd(0, R_PRESCALE, 32'd0, "ch0_prescale_reset");
    rd(0, R_SNAP, 32'd0, "ch0_snap_reset");
    wr(3, R_PERIOD, 32'd7);
    rd(3, R_PERIOD, 32'd0, "ch3_invalid_read");
    rd(2, R_PERIOD, 32'd599, "ch2_period_untouched");
    rd(0, R_PERIOD, 32'd599, "ch0_period_untouched");
    wr(2, 6, 32'hFFFF_FFFF);
    rd(2, 6, 32'd0, "ch2_reserved6");
    rd(2, 7, 32'd0, "ch2_reserved7");
    wr(2, R_PRESCALE, 32'hFFFF_FFFF);
    rd(2, R_PRESCALE, 32'h0000_00FF, "ch2_prescale_mask");

    // ch0 continuous, period 4, no prescale
    wr(0, R_PERIOD, 32'd4);
    wr(0, R_CONTROL, 32'd7);
    for (int i = 0; i < 6; i++) rd(0, R_COUNT, seq0[i], $sformatf("ch0_count_%0d", i));
    chk(32'(irq), 32'd1, "ch0_irq_first_zero");
    chk(32'(irq_vec), 32'd1, "ch0_irq_vec");
    wr(0, R_STATUS, 32'd0);
    for (int i = 0; i < 4; i++) rd(0, R_STATUS, st0[i], $sformatf("ch0_status_%0d", i));
    rd(0, R_COUNT, 32'd3, "ch0_count_a");
    rd(0, R_COUNT, 32'd2, "ch0_count_b");
    rd(0, R_COUNT, 32'd1, "ch0_count_c");
    wr(0, R_STATUS, 32'd0);               // coincides with a timeout event
    rd(0, R_STATUS, 32'd3, "ch0_to_event_wins");
    wr(0, R_STATUS, 32'd0);
    rd(0, R_STATUS, 32'd2, "ch0_to_cleared");
    chk(32'(irq), 32'd0, "irq_cleared");

    // ch1 one-shot, period 2, prescale 3
    wr(1, R_PRESCALE, 32'd3);
    wr(1, R_PERIOD, 32'd2);
    wr(1, R_CONTROL, 32'd4);
    for (int i = 0; i < 14; i++) rd(1, R_COUNT, seq1[i], $sformatf("ch1_count_%0d", i));
    rd(1, R_STATUS, 32'd1, "ch1_oneshot_done");
    chk(32'(irq_vec), 32'd1, "irq_vec_ch1_masked");
    rd(0, R_CONTROL, 32'd3, "ch0_control_kept");
    rd(0, R_PERIOD, 32'd4, "ch0_period_kept");
    wr(1, R_STATUS, 32'd0);
    rd(1, R_STATUS, 32'd0, "ch1_to_once");
    rd(1, R_COUNT, 32'd2, "ch1_count_idle");

    // PERIOD write while running, then snapshot
    wr(0, R_PERIOD, 32'd100);
    rd(0, R_COUNT, 32'd100, "ch0_period_load");
    rd(0, R_STATUS, 32'd3, "ch0_run_kept");
    wr(0, R_SNAP, 32'd0);
    rd(0, R_SNAP, 32'd98, "ch0_snap");

    // START|STOP together, STOP alone
    wr(1, R_CONTROL, 32'd12);
    rd(1, R_STATUS, 32'd2, "ch1_start_stop_run");
    rd(1, R_CONTROL, 32'd0, "ch1_control_pulses_zero");
    wr(1, R_CONTROL, 32'd8);
    rd(1, R_STATUS, 32'd0, "ch1_stopped");
    wr(1, R_CONTROL, 32'd12);
    rd(1, R_STATUS, 32'd2, "ch1_restarted");
    chk(32'(irq), 32'd1, "irq_before_reset");

    // Reset while running with a concurrent write
    reset_n    = 1'b0;
    address    = AW'(R_PERIOD);
    writedata  = 32'd9;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chk(readdata, 32'd0, "midrun_reset_readdata");
    chk(32'(irq), 32'd0, "midrun_reset_irq");
    chk(32'(irq_vec), 32'd0, "midrun_reset_irq_vec");
    @(negedge clk);
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd(0, R_COUNT, 32'd599, "post_reset_ch0_count");
    rd(0, R_PERIOD, 32'd599, "post_reset_write_dropped");
    rd(1, R_STATUS, 32'd0, "post_reset_ch1_status");
    rd(0, R_CONTROL, 32'd0, "post_reset_ch0_control");
    rd(0, R_SNAP, 32'd0, "post_reset_ch0_snap");
    rd(1, R_COUNT, 32'd599, "post_reset_ch1_count");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
